// File: rtl/perceptron_pkg.sv
// Shared types and constants for the perceptron sample loader and its sample buffer.
// Holds the loader state encoding, label-byte layout and sample width helpers.
package perceptron_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int LABEL_BIT  = 0;
  localparam int BYTE_W     = 8;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_FULL   = 2'd1,
    ST_REPLAY = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic int feat_w(input int in_dim, input int data_w);
    return in_dim * data_w;
  endfunction

  function automatic int sample_w(input int in_dim, input int data_w);
    return feat_w(in_dim, data_w) + 1;
  endfunction

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sample_buffer.sv
// Sample store: one row per sample, byte-lane writes per feature and label.
// Write lands on the clock edge; the read port is purely combinational.
module sample_buffer
  import perceptron_pkg::*;
#(
  parameter int N_SAMPLES = 3,
  parameter int IN_DIM    = 2,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic                              clk,
  input  logic [idx_w(N_SAMPLES)-1:0]       wr_idx,
  input  logic [IN_DIM:0]                   wr_en,
  input  logic [BYTE_W-1:0]                 wr_byte,
  input  logic [idx_w(N_SAMPLES)-1:0]       rd_idx,
  output logic [feat_w(IN_DIM, DATA_W)-1:0] rd_x,
  output logic                              rd_y
);

  localparam int XW = feat_w(IN_DIM, DATA_W);

  logic [XW-1:0] x_mem [N_SAMPLES];
  logic          y_mem [N_SAMPLES];

  // Upper feature bits and upper label bits are architecturally ignored.
  logic unused_bits;
  assign unused_bits = ^wr_byte;

  always_ff @(posedge clk) begin
    for (int l = 0; l < IN_DIM; l++) begin
      if (wr_en[l]) x_mem[wr_idx][l*DATA_W +: DATA_W] <= wr_byte[DATA_W-1:0];
    end
    if (wr_en[IN_DIM]) y_mem[wr_idx] <= wr_byte[LABEL_BIT];
  end

  assign rd_x = x_mem[rd_idx];
  assign rd_y = y_mem[rd_idx];

endmodule

// File: rtl/perceptron_sample_loader.sv
// Loads training samples from a byte stream, then replays them for up to EPOCHS epochs.
// Sample outputs are registered: 1 sample/cycle while s_ready is held; s_ready low freezes the sample.
module perceptron_sample_loader
  import perceptron_pkg::*;
#(
  parameter int N_SAMPLES = 3,
  parameter int IN_DIM    = 2,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int EPOCHS    = 8,
  parameter int EPOCH_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       in_valid,
  input  logic [BYTE_W-1:0]          in_data,
  output logic                       in_ready,
  input  logic                       start,
  input  logic                       stop_req,
  output logic                       s_valid,
  input  logic                       s_ready,
  output logic [IN_DIM*DATA_W-1:0]   s_x,
  output logic                       s_y,
  output logic                       s_last,
  output logic [EPOCH_W-1:0]         s_epoch,
  output logic                       busy,
  output logic                       done
);

  localparam int XW     = feat_w(IN_DIM, DATA_W);
  localparam int IDX_W  = idx_w(N_SAMPLES);
  localparam int BCNT_W = $clog2(IN_DIM + 1);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(N_SAMPLES - 1);
  localparam logic [EPOCH_W-1:0] LAST_EPOCH = EPOCH_W'(EPOCHS - 1);
  localparam logic [BCNT_W-1:0]  LABEL_POS  = BCNT_W'(IN_DIM);

  state_t state, state_nxt;

  logic [BCNT_W-1:0] byte_cnt;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              stop_flag;
  logic [IN_DIM:0]   wr_en;
  logic [XW-1:0]     rd_x;
  logic              rd_y;

  logic in_xfer, label_byte, load_last, launch, s_xfer, run_end;

  assign in_ready   = (state == ST_LOAD);
  assign busy       = (state == ST_REPLAY);
  assign done       = (state == ST_DONE);

  assign in_xfer    = in_valid && in_ready;
  assign label_byte = (byte_cnt == LABEL_POS);
  assign load_last  = in_xfer && label_byte && (wr_idx == LAST_IDX);
  assign launch     = (state == ST_FULL) && start;
  assign s_xfer     = s_valid && s_ready;
  // A stop_req coinciding with the last transfer of an epoch still ends the run there.
  assign run_end    = s_xfer && s_last &&
                      (stop_flag || stop_req || (s_epoch == LAST_EPOCH));

  always_comb begin
    wr_en = '0;
    for (int l = 0; l <= IN_DIM; l++) begin
      wr_en[l] = in_xfer && (byte_cnt == BCNT_W'(l));
    end
  end

  // The buffer is read at the index that becomes current after this edge.
  always_comb begin
    rd_idx = '0;
    if (!launch && (idx != LAST_IDX)) rd_idx = idx + 1'b1;
  end

  sample_buffer #(
    .N_SAMPLES (N_SAMPLES),
    .IN_DIM    (IN_DIM),
    .DATA_W    (DATA_W)
  ) u_buf (
    .clk     (clk),
    .wr_idx  (wr_idx),
    .wr_en   (wr_en),
    .wr_byte (in_data),
    .rd_idx  (rd_idx),
    .rd_x    (rd_x),
    .rd_y    (rd_y)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD:   if (load_last) state_nxt = ST_FULL;
      ST_FULL:   if (start)     state_nxt = ST_REPLAY;
      ST_REPLAY: if (run_end)   state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_DONE;
      default:   state_nxt = ST_LOAD;
    endcase
    if (clear) state_nxt = ST_LOAD;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      byte_cnt  <= '0;
      wr_idx    <= '0;
      idx       <= '0;
      stop_flag <= 1'b0;
      s_valid   <= 1'b0;
      s_x       <= '0;
      s_y       <= 1'b0;
      s_last    <= 1'b0;
      s_epoch   <= '0;
    end else begin
      if (in_xfer) begin
        if (label_byte) begin
          byte_cnt <= '0;
          wr_idx   <= (wr_idx == LAST_IDX) ? '0 : wr_idx + 1'b1;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end

      if (busy && stop_req) stop_flag <= 1'b1;

      if (launch) begin
        idx       <= '0;
        stop_flag <= 1'b0;
        s_epoch   <= '0;
        s_valid   <= 1'b1;
        s_x       <= rd_x;
        s_y       <= rd_y;
        s_last    <= (rd_idx == LAST_IDX);
      end else if (s_xfer) begin
        if (run_end) begin
          s_valid <= 1'b0;
        end else begin
          idx    <= rd_idx;
          s_x    <= rd_x;
          s_y    <= rd_y;
          s_last <= (rd_idx == LAST_IDX);
          if (s_last) s_epoch <= s_epoch + 1'b1;
        end
      end
    end
  end

endmodule
